// File: rtl/jbus_xfer_ctrl_pkg.sv
// Shared types for the bus transfer controller: FSM state encoding and width helpers.
package jbus_xfer_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_EN   = 3'd1,
    ST_SET  = 3'd2,
    ST_HOLD = 3'd3,
    ST_DONE = 3'd4
  } xfer_state_e;

  // Index width for a set of n items; a single item still needs one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/jbus_xfer_ctrl_arbiter.sv
// Combinational round-robin pick: first requester at or after the pointer, wrapping.
module jrr_arbiter
  import jbus_xfer_ctrl_pkg::*;
#(
  parameter int unsigned NREQ = 2
) (
  input  logic [NREQ-1:0]         req_i,
  input  logic [idx_w(NREQ)-1:0]  ptr_i,
  output logic [NREQ-1:0]         win_c_o,
  output logic                    valid_c_o
);

  localparam int unsigned PW = idx_w(NREQ);

  int unsigned idx;

  always_comb begin
    win_c_o   = '0;
    valid_c_o = 1'b0;
    idx       = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = (32'(ptr_i) + i) % NREQ;
      if (!valid_c_o && req_i[PW'(idx)]) begin
        win_c_o[PW'(idx)] = 1'b1;
        valid_c_o         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/jbus_xfer_ctrl.sv
// Register-to-register move sequencer on the shared 8-bit bus: enable, then set,
// then drop set while enable holds, so the destination never latches a floating bus.
module jbus_xfer_ctrl
  import jbus_xfer_ctrl_pkg::*;
#(
  parameter int unsigned NREG = 4,
  parameter int unsigned IW   = 2,
  parameter int unsigned NREQ = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*IW-1:0]   req_src,
  input  logic [NREQ*IW-1:0]   req_dst,
  input  logic [NREQ-1:0]      req_bus1,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic                 err,
  output logic                 busy,
  output logic [NREG-1:0]      reg_we,
  output logic [NREG-1:0]      reg_ws,
  output logic                 bus1
);

  localparam int unsigned PW = idx_w(NREQ);

  xfer_state_e      state_q, state_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW-1:0]    win_q, win_d;
  logic [IW-1:0]    src_q, src_d;
  logic [IW-1:0]    dst_q, dst_d;
  logic             b1_q, b1_d;

  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [NREQ-1:0]  done_q, done_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic [NREG-1:0]  we_q, we_d;
  logic [NREG-1:0]  ws_q, ws_d;
  logic             bus1_q, bus1_d;

  logic [NREQ-1:0]  arb_win_c;
  logic             arb_valid_c;
  logic [PW-1:0]    win_idx_c;
  logic [IW-1:0]    sel_src_c;
  logic [IW-1:0]    sel_dst_c;
  logic             sel_b1_c;
  logic             sel_bad_c;

  // One-hot register select, truncated to the registers actually present.
  function automatic logic [NREG-1:0] dec_f(input logic [IW-1:0] idx);
    logic [NREG-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < NREG; i++) r[i] = (idx == IW'(i));
    return r;
  endfunction

  function automatic logic [NREQ-1:0] idx2oh_f(input logic [PW-1:0] idx);
    logic [NREQ-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < NREQ; i++) r[i] = (idx == PW'(i));
    return r;
  endfunction

  function automatic logic [PW-1:0] oh2idx_f(input logic [NREQ-1:0] oh);
    logic [PW-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < NREQ; i++) if (oh[i]) r = PW'(i);
    return r;
  endfunction

  jrr_arbiter #(.NREQ(NREQ)) u_arb (
    .req_i     (req),
    .ptr_i     (ptr_q),
    .win_c_o   (arb_win_c),
    .valid_c_o (arb_valid_c)
  );

  // Winner's request fields, only meaningful in the accept cycle.
  assign win_idx_c = oh2idx_f(arb_win_c);
  assign sel_src_c = req_src[32'(win_idx_c)*IW +: IW];
  assign sel_dst_c = req_dst[32'(win_idx_c)*IW +: IW];
  assign sel_b1_c  = req_bus1[win_idx_c];
  assign sel_bad_c = (sel_src_c == sel_dst_c) || (32'(sel_src_c) >= NREG) ||
                     (32'(sel_dst_c) >= NREG);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      b1_q    <= 1'b0;
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      we_q    <= '0;
      ws_q    <= '0;
      bus1_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      b1_q    <= b1_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      we_q    <= we_d;
      ws_q    <= ws_d;
      bus1_q  <= bus1_d;
    end
  end

  // Outputs are computed for the state being entered, so they line up with state_q.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    src_d   = src_q;
    dst_d   = dst_q;
    b1_d    = b1_q;
    gnt_d   = '0;
    done_d  = '0;
    err_d   = 1'b0;
    we_d    = '0;
    ws_d    = '0;
    bus1_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (arb_valid_c) begin
          win_d = win_idx_c;
          src_d = sel_src_c;
          dst_d = sel_dst_c;
          b1_d  = sel_b1_c;
          gnt_d = arb_win_c;
          if (sel_bad_c) begin
            state_d = ST_DONE;
            done_d  = arb_win_c;
            err_d   = 1'b1;
          end else begin
            state_d = ST_EN;
            we_d    = dec_f(sel_src_c);
            bus1_d  = sel_b1_c;
          end
        end
      end
      ST_EN: begin
        state_d = ST_SET;
        we_d    = dec_f(src_q);
        ws_d    = dec_f(dst_q);
        bus1_d  = b1_q;
      end
      ST_SET: begin
        state_d = ST_HOLD;
        we_d    = dec_f(src_q);
        bus1_d  = b1_q;
      end
      ST_HOLD: begin
        state_d = ST_DONE;
        done_d  = idx2oh_f(win_q);
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        ptr_d   = PW'((32'(win_q) + 1) % NREQ);
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  assign gnt    = gnt_q;
  assign done   = done_q;
  assign err    = err_q;
  assign busy   = busy_q;
  assign reg_we = we_q;
  assign reg_ws = ws_q;
  assign bus1   = bus1_q;

endmodule

// File: doc/jbus_xfer_ctrl.md
Name: jbus_xfer_ctrl

Overview:
- Sequences register-to-register moves over the shared 8-bit bus: drives per-register enable (we) and set (ws) lines plus the bus1 control.
- Arbitrates round-robin among NREQ requesters, each asking for one transfer src -> dst.
- Orders enable before set, and drops set before enable, so the destination never latches a floating bus.
- Sits between instruction-control logic and the register file built from the byte/register/enabler parts.

Parameters:
NREG, 4, number of bus registers controlled (NREG <= 2**IW)
IW, 2, width of a register index
NREQ, 2, number of requesters

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req  input  NREQ  transfer request per requester; hold high until gnt
req_src  input  NREQ*IW  source index per requester; slice k = [k*IW +: IW]
req_dst  input  NREQ*IW  destination index per requester, same packing
req_bus1  input  NREQ  assert bus1 during the transfer (source byte forced to 0x01 path)
gnt  output  NREQ  one-cycle pulse: request accepted
done  output  NREQ  one-cycle pulse: transfer finished or rejected
err  output  1  one-cycle pulse with done: request rejected
busy  output  1  high in any state other than IDLE
reg_we  output  NREG  one-hot register enable to bus
reg_ws  output  NREG  one-hot register set from bus
bus1  output  1  bus1 control

Behaviour:
- All outputs are registered. Reset (async, rst_n=0) forces state IDLE, round-robin pointer 0, and every output 0 immediately. Reset mid-transfer aborts it with no done pulse.
- States: IDLE, EN, SET, HOLD, DONE.
- IDLE:
  - If any req bit is high, the arbiter picks the first set bit at or after the pointer, wrapping modulo NREQ.
  - Captures that requester's src, dst and bus1 into internal registers.
  - If src==dst, src>=NREG or dst>=NREG, next state is DONE with an error flag; otherwise next state is EN.
- EN (cycle T+1 after the accept cycle T):
  - gnt[w]=1.
  - reg_we[src]=1, bus1=captured bus1.
  - On the error path, gnt[w] pulses in the DONE cycle instead.
- SET (T+2): reg_we[src]=1, reg_ws[dst]=1, bus1 held.
- HOLD (T+3): reg_we[src]=1, reg_ws=0, bus1 held.
- DONE (T+4 normal; T+1 error):
  - reg_we=0, reg_ws=0, bus1=0.
  - done[w]=1; err=1 only on the error path.
  - Pointer advances to (w+1) mod NREQ.
  - Next state is IDLE.
- Throughput: one transfer per 5 cycles; one per 2 cycles for rejected requests.
- Request fields are sampled only in the accept cycle. Later changes to req_src, req_dst or req_bus1 are ignored.
- Dropping req before gnt is legal. It is not queued, and the dropped request is never granted.
- Invariants, checked every cycle:
  - reg_we and reg_ws are each at most one-hot.
  - reg_ws != 0 implies reg_we != 0.
  - reg_ws and reg_we never target the same register.
  - gnt and done are each at most one-hot.
  - busy==0 implies all control outputs are 0.
- Simultaneous requests: only one is granted per IDLE visit; the others stay pending while req is held.
- Starvation-free: a held request is granted within NREQ transfers.

Decomposition:
- Shared include file: state encodings (IDLE=0, EN=1, SET=2, HOLD=3, DONE=4) and the NREQ-slice index macros.
- One sub-module, jrr_arbiter:
  - Parameter NREQ.
  - Inputs: req, pointer. Output: one-hot winner plus a valid flag.
  - Purely combinational; the pointer register lives in jbus_xfer_ctrl.
- One-hot reg_we/reg_ws generation reuses the existing parametric decoder (N=IW, N2=2**IW), truncated to NREG.

Test Plan:
- Reset state: hold rst_n=0, then release. All outputs 0, busy=0. Assert rst_n=0 in SET: reg_we and reg_ws drop to 0 asynchronously before the next edge, with no done.
- Single transfer: req[0]=1, src=1, dst=2, bus1=0 sampled at T. Expect:
  - T+1: gnt=01, reg_we=0010.
  - T+2: reg_we=0010, reg_ws=0100.
  - T+3: reg_we=0010, reg_ws=0000.
  - T+4: all 0, done=01, err=0.
- bus1 path: req[1], src=3, dst=0, bus1=1. bus1=1 exactly in T+1..T+3; reg_ws=0001 in T+2 only; done=10 at T+4.
- Error: req[0], src=dst=2. gnt=01, done=01 and err=1 all at T+1; reg_we and reg_ws stay 0 throughout. Repeat with dst=3 and NREG=3 (out of range): same response.
- Arbitration: req=11 held continuously with valid fields. Grants alternate 01, 10, 01, 10, spaced 5 cycles apart; neither requester waits more than one transfer.
- Field change and drop: change req_src after accept; reg_we still follows the sampled src. Pulse req[1] for one cycle during busy; it is never granted.
